// File: rtl/seq_divider_pkg.sv
// Shared constants and state encoding for the 16-bit sequential restoring divider.
package seq_divider_pkg;

  localparam int WIDTH  = 16;
  localparam int ITERS  = 16;
  localparam int CNT_W  = $clog2(ITERS);
  localparam int GROUPS = WIDTH / 4;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_adder.sv
// 16-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
module seq_divider_adder
  import seq_divider_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0]  gen;
  logic [WIDTH-1:0]  prop;
  logic [WIDTH:0]    carry;
  logic [GROUPS-1:0] grp_g;
  logic [GROUPS-1:0] grp_p;
  logic [GROUPS:0]   grp_c;

  assign gen  = a & b;
  assign prop = a ^ b;

  always_comb begin
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    carry = '0;
    for (int k = 0; k < GROUPS; k++) begin
      grp_g[k] = gen[4*k+3]
               | (prop[4*k+3] & gen[4*k+2])
               | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
               | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
      grp_p[k] = &prop[4*k +: 4];
    end
    grp_c[0] = cin;
    for (int k = 0; k < GROUPS; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
    // Carries inside each group depend only on that group's carry-in.
    for (int k = 0; k < GROUPS; k++) begin
      carry[4*k]   = grp_c[k];
      carry[4*k+1] = gen[4*k] | (prop[4*k] & grp_c[k]);
      carry[4*k+2] = gen[4*k+1]
                   | (prop[4*k+1] & gen[4*k])
                   | (prop[4*k+1] & prop[4*k] & grp_c[k]);
      carry[4*k+3] = gen[4*k+2]
                   | (prop[4*k+2] & gen[4*k+1])
                   | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                   | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & grp_c[k]);
    end
    carry[WIDTH] = grp_c[GROUPS];
  end

  assign sum  = prop ^ carry[WIDTH-1:0];
  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Unsigned 16-bit restoring divider, one quotient bit per cycle, MSB first.
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_sh_q, quo_sh_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial_diff;
  logic             carry_out;
  logic             ge;
  logic [WIDTH-1:0] new_rem;
  logic [WIDTH-1:0] new_quo;

  assign shifted = {rem_q, dvd_q[WIDTH-1]};

  // Trial subtraction as shifted + ~divisor + 1; carry out means no borrow.
  seq_divider_adder u_adder (
    .a    (shifted[WIDTH-1:0]),
    .b    (~dvs_q),
    .cin  (1'b1),
    .sum  (trial_diff),
    .cout (carry_out)
  );

  assign ge      = shifted[WIDTH] | carry_out;
  assign new_rem = ge ? trial_diff : shifted[WIDTH-1:0];
  assign new_quo = {quo_sh_q[WIDTH-2:0], ge};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_sh_d    = quo_sh_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          dvd_d    = dividend;
          dvs_d    = divisor;
          rem_d    = '0;
          quo_sh_d = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        dvd_d    = {dvd_q[WIDTH-2:0], 1'b0};
        rem_d    = new_rem;
        quo_sh_d = new_quo;
        cnt_d    = cnt_q + 1'b1;
        // The final iteration writes straight into the result registers.
        if (cnt_q == LAST_ITER) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          quotient_d  = new_quo;
          remainder_d = new_rem;
          dbz_d       = (dvs_q == '0);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_sh_q    <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_sh_q    <= quo_sh_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor checks each done pulse.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drives one start pulse and records what the scoreboard should see 16 edges later.
  task automatic applyStimulus(input logic [15:0] dvd, input logic [15:0] dvs,
                               input logic [15:0] q, input logic [15:0] r, input logic dbz);
    exp_t e;
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk);
    #1;
    e.q = q; e.r = r; e.dbz = dbz; e.cyc = cyc + 16;
    sb_q.push_back(e);
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("done_within_budget", {31'd0, seen}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got done=1 expected none pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("quotient", {16'd0, quotient}, {16'd0, e.q});
        checkOutput("remainder", {16'd0, remainder}, {16'd0, e.r});
        checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        checkOutput("done_latency", cyc, e.cyc);
        checkOutput("busy_low_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rd, rs, rq, rr;
    rst_n = 1'b0;
    #12;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_quotient", {16'd0, quotient}, 32'd0);
    checkOutput("reset_remainder", {16'd0, remainder}, 32'd0);
    checkOutput("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    waitDone();
    applyStimulus(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0);
    waitDone();
    applyStimulus(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    waitDone();
    applyStimulus(16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0);
    waitDone();
    applyStimulus(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
    waitDone();
    applyStimulus(16'd9, 16'd3, 16'd3, 16'd0, 1'b0);
    waitDone();
    @(negedge clk);

    // A start arriving mid-run must neither restart nor relatch operands.
    applyStimulus(16'd3, 16'd9, 16'd0, 16'd3, 1'b0);
    repeat (7) @(negedge clk);
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_ignored_start", {31'd0, busy}, 32'd1);
    waitDone();
    repeat (3) @(negedge clk);

    // Second start lands in the done cycle, so pulses are 17 cycles apart.
    applyStimulus(16'd1000, 16'd10, 16'd100, 16'd0, 1'b0);
    waitDone();
    applyStimulus(16'd77, 16'd8, 16'd9, 16'd5, 1'b0);
    waitDone();
    @(negedge clk);

    applyStimulus(16'd1234, 16'd5, 16'd246, 16'd4, 1'b0);
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_quotient", {16'd0, quotient}, 32'd0);
    checkOutput("abort_remainder", {16'd0, remainder}, 32'd0);
    checkOutput("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(16'd40000, 16'd123, 16'd325, 16'd25, 1'b0);
    waitDone();

    for (int i = 0; i < 12; i++) begin
      rd = 16'($urandom());
      case ($urandom_range(0, 3))
        0: rs = 16'd0;
        1: rs = 16'($urandom_range(1, 15));
        default: rs = 16'($urandom());
      endcase
      if (rs == 16'd0) begin
        rq = 16'hFFFF;
        rr = rd;
      end else begin
        rq = rd / rs;
        rr = rd % rs;
      end
      applyStimulus(rd, rs, rq, rr, (rs == 16'd0));
      waitDone();
    end
    repeat (3) @(negedge clk);

    checkOutput("scoreboard_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
